// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned DEFAULT_IMEM_WORDSIZE = 32;
    localparam int unsigned FETCH_STRIDE          = 8;
    localparam logic [31:0] DEFAULT_RESET_PC      = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]                      pc;
        logic [DEFAULT_IMEM_WORDSIZE-1:0] instr1;
        logic [DEFAULT_IMEM_WORDSIZE-1:0] instr2;
    } fetch_bundle_t;

endpackage

// File: rtl/fetch_queue.sv
// Flushable circular FIFO of fetch bundles; flush overrides enqueue and dequeue.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       enq_i,
    input  fetch_bundle_t              enq_data_i,
    input  logic                       deq_i,
    output fetch_bundle_t              head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_bundle_t   mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_enq, do_deq;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign count_o = count_q;
    // Head reads as zero while empty so downstream never sees stale bundles.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_enq   = enq_i & ~flush_i;
        do_deq   = deq_i & ~empty_o & ~flush_i;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_enq) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_deq) rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_enq && !do_deq) count_d = count_q + 1'b1;
            else if (!do_enq && do_deq) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem_q[wr_ptr_q] <= enq_data_i;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues paired imem reads and queues returned bundles.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
    parameter int unsigned FQ_DEPTH      = 4,
    parameter int unsigned IMEM_WORDSIZE = DEFAULT_IMEM_WORDSIZE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic [31:0]              imem_addr1,
    output logic [31:0]              imem_addr2,
    input  logic [IMEM_WORDSIZE-1:0] imem_instr1,
    input  logic [IMEM_WORDSIZE-1:0] imem_instr2,
    output logic                     fetch_valid,
    input  logic                     fetch_ready,
    output logic [31:0]              fetch_pc,
    output logic [IMEM_WORDSIZE-1:0] fetch_instr1,
    output logic [IMEM_WORDSIZE-1:0] fetch_instr2
);

    localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);

    logic [31:0]     pc_q, pc_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic            issue, credit_ok, enq, deq;
    logic            q_empty, q_full;
    logic [CntW-1:0] q_count;
    fetch_bundle_t   enq_data, head;

    assign imem_addr1 = pc_q;
    assign imem_addr2 = pc_q + 32'd4;

    // Registered count only: a same-cycle dequeue does not free a credit.
    assign credit_ok = (32'(q_count) + 32'(inflight_q)) < FQ_DEPTH;
    assign issue     = fetch_en & ~redirect_valid & credit_ok;
    assign enq       = inflight_q & ~redirect_valid;
    assign deq       = fetch_valid & fetch_ready;
    assign enq_data  = '{pc: inflight_pc_q, instr1: imem_instr1, instr2: imem_instr2};

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'h3;
        end else if (issue) begin
            pc_d          = pc_q + FETCH_STRIDE;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect_valid),
        .enq_i      (enq),
        .enq_data_i (enq_data),
        .deq_i      (deq),
        .head_o     (head),
        .count_o    (q_count),
        .empty_o    (q_empty),
        .full_o     (q_full)
    );

    assign fetch_valid  = ~q_empty;
    assign fetch_pc     = head.pc;
    assign fetch_instr1 = head.instr1;
    assign fetch_instr2 = head.instr2;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(enq && q_full));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed stimulus pushes expected bundles, a monitor pops them.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, fetch_en, redirect_valid, fetch_ready, fetch_valid;
    logic [31:0] redirect_pc, imem_addr1, imem_addr2, imem_instr1, imem_instr2;
    logic [31:0] fetch_pc, fetch_instr1, fetch_instr2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] i1;
        logic [31:0] i2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC      (32'h0000_0000),
        .FQ_DEPTH      (4),
        .IMEM_WORDSIZE (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr1     (imem_addr1),
        .imem_addr2     (imem_addr2),
        .imem_instr1    (imem_instr1),
        .imem_instr2    (imem_instr2),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .fetch_instr1   (fetch_instr1),
        .fetch_instr2   (fetch_instr2)
    );

    // 1-cycle imem whose word at byte address A is A>>2.
    always @(posedge clk) begin
        imem_instr1 <= imem_addr1 >> 2;
        imem_instr2 <= imem_addr2 >> 2;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && fetch_valid && fetch_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bundle: got pc=%h i1=%h i2=%h, required no bundle",
                         fetch_pc, fetch_instr1, fetch_instr2);
            end else begin
                e = exp_q.pop_front();
                if ({fetch_pc, fetch_instr1, fetch_instr2} !== e) begin
                    errors++;
                    $display("FAIL bundle: got pc=%h i1=%h i2=%h, required pc=%h i1=%h i2=%h",
                             fetch_pc, fetch_instr1, fetch_instr2, e.pc, e.i1, e.i2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2);
        exp_q.push_back('{pc: pc, i1: i1, i2: i2});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(fetch_valid), 32'd0);
        chk({tag, "_addr1"}, imem_addr1, 32'h0000_0000);
        chk({tag, "_addr2"}, imem_addr2, 32'h0000_0004);
        chk({tag, "_pc"}, fetch_pc, 32'h0);
        chk({tag, "_instr1"}, fetch_instr1, 32'h0);
        chk({tag, "_instr2"}, fetch_instr2, 32'h0);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        fetch_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        fetch_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick();
        tick();
        chk_reset_outputs("reset");

        // Streaming: five issues, one bundle per cycle from cycle 2.
        push_exp(32'h00, 32'h0, 32'h1);
        push_exp(32'h08, 32'h2, 32'h3);
        push_exp(32'h10, 32'h4, 32'h5);
        push_exp(32'h18, 32'h6, 32'h7);
        push_exp(32'h20, 32'h8, 32'h9);
        rst_n       = 1'b1;
        fetch_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            fetch_en = (c < 5);
            chk("stream_valid", 32'(fetch_valid), 32'((c >= 2) && (c <= 6)));
            tick();
        end
        chk("stream_pc_hold", imem_addr1, 32'h28);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: credits stop issue at four, then drain in order.
        do_reset();
        push_exp(32'h00, 32'h0, 32'h1);
        push_exp(32'h08, 32'h2, 32'h3);
        push_exp(32'h10, 32'h4, 32'h5);
        push_exp(32'h18, 32'h6, 32'h7);
        fetch_en    = 1'b1;
        fetch_ready = 1'b0;
        repeat (9) tick();
        chk("bp_pc_hold", imem_addr1, 32'h20);
        chk("bp_valid", 32'(fetch_valid), 32'd1);
        chk("bp_head_pc", fetch_pc, 32'h0);
        tick();
        fetch_en    = 1'b0;
        fetch_ready = 1'b1;
        for (int c = 10; c < 15; c++) begin
            chk("bp_drain_valid", 32'(fetch_valid), 32'(c <= 13));
            tick();
        end
        chk("bp_pc_after", imem_addr1, 32'h20);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Redirect with three bundles queued and one in flight.
        do_reset();
        push_exp(32'h100, 32'h40, 32'h41);
        push_exp(32'h108, 32'h42, 32'h43);
        fetch_en    = 1'b1;
        fetch_ready = 1'b0;
        repeat (4) tick();
        chk("rd_valid_before", 32'(fetch_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick();
        redirect_valid = 1'b0;
        fetch_ready    = 1'b1;
        chk("rd_valid_t1", 32'(fetch_valid), 32'd0);
        chk("rd_pc_empty", fetch_pc, 32'h0);
        chk("rd_addr_aligned", imem_addr1, 32'h100);
        tick();
        chk("rd_valid_t2", 32'(fetch_valid), 32'd0);
        tick();
        fetch_en = 1'b0;
        chk("rd_valid_t3", 32'(fetch_valid), 32'd1);
        tick();
        chk("rd_valid_t4", 32'(fetch_valid), 32'd1);
        tick();
        chk("rd_valid_t5", 32'(fetch_valid), 32'd0);
        chk("rd_pc_hold", imem_addr1, 32'h110);
        chk("rd_drained", 32'(exp_q.size()), 32'd0);

        // Redirect coinciding with a dequeue and an imem response; wrap at the top of memory.
        do_reset();
        push_exp(32'h0000_0000, 32'h0000_0000, 32'h0000_0001);
        push_exp(32'hFFFF_FFF8, 32'h3FFF_FFFE, 32'h3FFF_FFFF);
        fetch_en    = 1'b1;
        fetch_ready = 1'b1;
        tick();
        tick();
        chk("wr_valid_c2", 32'(fetch_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        chk("wr_valid_c3", 32'(fetch_valid), 32'd0);
        chk("wr_addr1_top", imem_addr1, 32'hFFFF_FFF8);
        chk("wr_addr2_top", imem_addr2, 32'hFFFF_FFFC);
        tick();
        fetch_en = 1'b0;
        chk("wr_valid_c4", 32'(fetch_valid), 32'd0);
        chk("wr_addr1_wrap", imem_addr1, 32'h0000_0000);
        chk("wr_addr2_wrap", imem_addr2, 32'h0000_0004);
        tick();
        chk("wr_valid_c5", 32'(fetch_valid), 32'd1);
        tick();
        chk("wr_valid_c6", 32'(fetch_valid), 32'd0);
        chk("wr_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-stream, between clock edges.
        do_reset();
        fetch_en    = 1'b1;
        fetch_ready = 1'b0;
        repeat (3) tick();
        chk("ar_valid_before", 32'(fetch_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        tick();
        tick();
        fetch_en = 1'b0;
        rst_n    = 1'b1;
        tick();
        chk("ar_valid_after", 32'(fetch_valid), 32'd0);
        chk("ar_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Front-end fetch sequencer for the dual-port, 1-cycle-latency instruction memory. It owns the PC and drives both imem read addresses each cycle (PC and PC+4). It tracks the in-flight read and buffers returned instruction pairs in a small flushable queue. It presents {pc, instr1, instr2} bundles to decode with a valid/ready handshake, and handles back-end redirects by killing in-flight and queued fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [2:0] must be 0.
FQ_DEPTH, 4, fetch-queue entries, each one bundle; legal range 2..16, power of two.
IMEM_WORDSIZE, 32, instruction width; matches the imem word size.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
fetch_en  in  1  when low, no new fetches issue; queued bundles still drain.
redirect_valid  in  1  one-cycle pulse that redirects the PC.
redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0.
imem_addr1  out  32  byte address of slot 0; equals pc.
imem_addr2  out  32  byte address of slot 1; equals pc+4.
imem_instr1  in  IMEM_WORDSIZE  imem data for addr1, valid the cycle after issue.
imem_instr2  in  IMEM_WORDSIZE  imem data for addr2, valid the cycle after issue.
fetch_valid  out  1  queue head is valid.
fetch_ready  in  1  decode accepts the head this cycle.
fetch_pc  out  32  PC of the head bundle's slot 0.
fetch_instr1  out  IMEM_WORDSIZE  head slot 0 instruction.
fetch_instr2  out  IMEM_WORDSIZE  head slot 1 instruction.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, inflight=0, queue empty (count=0, rd/wr pointers=0).
  - fetch_valid=0; imem_addr1=RESET_PC, imem_addr2=RESET_PC+4.
  - fetch_pc and fetch_instr* read 0 while empty.
- imem_addr1/2 are combinational from the pc register only.
- Issue condition in cycle T: fetch_en & !redirect_valid & (count + inflight < FQ_DEPTH).
  - count and inflight are the registered values; a same-cycle dequeue does not free a credit.
- On issue:
  - inflight_n=1, inflight_pc_n=pc.
  - pc_n=pc+8, modulo 2^32; wrap-around is silent.
- No issue: pc holds and inflight_n=0.
- Response: if inflight=1 in cycle T+1, enqueue {inflight_pc, imem_instr1, imem_instr2} at the end of T+1. fetch_valid is visible in T+2, so issue-to-valid latency is 2 cycles.
- Dequeue when fetch_valid & fetch_ready; the head advances at the clock edge.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - The credit rule guarantees the queue never overflows; a write to a full queue is an assertion failure.
- Redirect in cycle T (highest priority):
  - At the end of T: pc=redirect_pc & ~3, queue flushed (count=0, pointers reset), inflight=0.
  - Any imem response arriving in T+1 is discarded.
  - No issue in T. First issue at T+1 if fetch_en; fetch_valid rises at T+3.
  - A handshake in the redirect cycle counts as accepted by decode; the flush still applies.
  - fetch_valid=0 in T+1 and T+2.
- fetch_en deasserted mid-stream: the in-flight response still enqueues; pc holds at the next unissued address.
- Steady state with fetch_en=1, fetch_ready=1 and FQ_DEPTH>=3 gives one bundle per cycle.
- PC alignment: pc[2] may be 1 after a redirect. Bundles are then pc, pc+4, and the next pc is pc+8. There is no realignment.
- Reset mid-operation asynchronously clears all state; any in-flight read is lost.

Decomposition:
- Package fetch_pkg holds:
  - fetch_bundle_t struct {logic [31:0] pc; logic [IMEM_WORDSIZE-1:0] instr1, instr2;}
  - localparam FETCH_STRIDE=8
  - the default RESET_PC
- Sub-module fetch_queue: circular FIFO of fetch_bundle_t with parameter DEPTH.
  - Ports: enq, deq, flush, count, head, empty, full.
  - Flush has priority over enq/deq.
- fetch_ctrl holds the pc, inflight and issue/credit logic.

Test Plan:
- Reset release, fetch_en=1, fetch_ready=1, imem model returns addr>>2 → fetch_valid at cycle 2; bundles (0,0,1), (8,2,3), (16,4,5)… one per cycle.
- fetch_ready=0 for 10 cycles → exactly 4 bundles queued. Issues stop at count+inflight=4, and pc holds at 0x20. On release, bundles drain in order with no loss or duplication.
- redirect_valid pulse with redirect_pc=0x103 while the queue holds 3 bundles → fetch_valid=0 for 2 cycles, then the bundle is pc=0x100 with instr words 0x40 and 0x41. Stale in-flight data never appears.
- Redirect in the same cycle as a dequeue and an imem response → the dequeued bundle counts as consumed, the response is dropped, and count=0 next cycle.
- pc=0xFFFF_FFF8 (via redirect) → bundle at 0xFFFF_FFF8, next pc=0x0000_0000 (wrap).
- fetch_en toggled 1→0 after one issue → exactly one more bundle enqueued; pc stable; rst_n pulsed mid-stream → all outputs return to reset values asynchronously.
